spike_window_counter: RTL

Downstream rate-decoding stage for the neuron network's final 1-bit output. It counts spikes over a fixed window of WINDOW enabled samples and computes a fire decision by comparing the count against a threshold. Each completed window's result is placed in a one-entry valid/ready output slot so a slower consumer (readout, UART, host pins) can collect it. Sampling is never stalled by the consumer; unread results are dropped and flagged instead.

---
 rtl/neuron_pkg.sv | 13 +
 rtl/spike_out_slot.sv | 80 ++++++++
 rtl/spike_window_counter.sv | 80 ++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron readout stages: default window shape and
// the state type for the one-entry output slot.
package neuron_pkg;

    localparam int WINDOW_DEFAULT = 16;
    localparam int THRESH_DEFAULT = 8;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/spike_out_slot.sv
// One-entry valid/ready result register. Loads never stall the producer: a load
// into a full slot without a handshake is dropped and flagged as overrun.
//
//   state      | meaning
//   SLOT_EMPTY | no result held, valid_o=0
//   SLOT_FULL  | result held and stable until the consumer takes it, valid_o=1
module spike_out_slot
    import neuron_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] count_i,
    input  logic          fire_i,
    input  logic          ready_i,
    input  logic          clear_ovr_i,
    output logic [CW-1:0] count_o,
    output logic          fire_o,
    output logic          valid_o,
    output logic          overrun_o
);

    slot_state_e   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          fire_q, fire_d;
    logic          ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        fire_d  = fire_q;
        ovr_d   = ovr_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                    count_d = count_i;
                    fire_d  = fire_i;
                end
            end
            SLOT_FULL: begin
                // A handshake frees the entry in the same edge a new result arrives.
                if (load_i && ready_i) begin
                    count_d = count_i;
                    fire_d  = fire_i;
                end else if (load_i) begin
                    ovr_d = 1'b1;
                end else if (ready_i) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
        if (clear_ovr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            count_q <= '0;
            fire_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            fire_q  <= fire_d;
            ovr_q   <= ovr_d;
        end
    end

    assign count_o   = count_q;
    assign fire_o    = fire_q;
    assign valid_o   = (state_q == SLOT_FULL);
    assign overrun_o = ovr_q;

endmodule

// File: rtl/spike_window_counter.sv
// Counts spikes over windows of WINDOW enabled samples and hands each window's
// count and fire decision to a one-entry output slot.
module spike_window_counter
    import neuron_pkg::*;
#(
    parameter  int WINDOW = WINDOW_DEFAULT,
    parameter  int THRESH = THRESH_DEFAULT,
    localparam int CW     = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          spike_in,
    input  logic          clear,
    output logic [CW-1:0] out_count,
    output logic          out_fire,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun
);

    localparam int IW = $clog2(WINDOW);

    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] sum;
    logic          last;
    logic          complete;
    logic          fire;

    assign sum      = acc_q + CW'(spike_in);
    assign last     = (idx_q == IW'(WINDOW - 1));
    assign complete = en && !clear && last;
    assign fire     = (sum >= CW'(THRESH));

    // The closing sample restarts the window in the same edge, so no sample is lost.
    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        if (clear) begin
            idx_d = '0;
            acc_d = '0;
        end else if (en) begin
            if (last) begin
                idx_d = '0;
                acc_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

    spike_out_slot #(
        .CW (CW)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_i      (complete),
        .count_i     (sum),
        .fire_i      (fire),
        .ready_i     (out_ready),
        .clear_ovr_i (clear),
        .count_o     (out_count),
        .fire_o      (out_fire),
        .valid_o     (out_valid),
        .overrun_o   (overrun)
    );

endmodule
